branch_predict_unit: RTL and testbench

Parametrised dynamic branch predictor and recovery controller for the pipelined mMIPS core. At decode it looks up a direct-mapped table of saturating counters indexed by the branch PC and steers fetch to the predicted path. One cycle later it resolves the branch from the register operands. On a misprediction it issues a flush and a recovery select. It also updates the table and keeps hit/miss statistics.

---
 rtl/branch_predict_unit.sv | 129 ++++++++++++
 tb/tb_branch_predict_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - dynamic branch predictor and misprediction recovery controller
//
// Purpose: predicts conditional branches at decode from a direct-mapped table
// of saturating counters (or a static policy), resolves them one cycle later
// from the register operands, and issues flush plus recovery select on a miss.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   hold              pipeline stall, freezes all state
//   branch_op         decode op: 0 none, 1 beq, 2 bne, 3 jump
//   pc_decode         PC of the decode-stage instruction
//   data_reg1/2       branch operands, valid in the resolve cycle
//   branch_addr_mux   registered prediction: 1 = fetch from branch target
//   adder_mux         pulse: recover to sequential path
//   branch_redirect   pulse: recover to branch target
//   flush             pulse on any misprediction
//   stat_branches     saturating resolved-branch count
//   stat_mispredicts  saturating misprediction count
module branch_predict_unit #(
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = 6,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int MODE     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [1:0]        branch_op,
  input  logic [ADDR_W-1:0] pc_decode,
  input  logic [31:0]       data_reg1,
  input  logic [31:0]       data_reg2,
  output logic              branch_addr_mux,
  output logic              adder_mux,
  output logic              branch_redirect,
  output logic              flush,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_THR = CTR_W'(1) << (CTR_W - 1);

  logic [CTR_W-1:0] ctrTable [DEPTH];

  logic             pendValid;
  logic [1:0]       pendOp;
  logic [IDX_W-1:0] pendIdx;
  logic             pendPred;

  logic [IDX_W-1:0] lookupIdx;
  logic             unusedPcBits;
  logic             isCond;
  logic             predNow;
  logic             lookupNow;
  logic             resolveNow;
  logic             actual;
  logic             mispredict;
  logic [CTR_W-1:0] curCtr;
  logic [CTR_W-1:0] ctrNext;

  assign lookupIdx    = pc_decode[IDX_W+1:2];
  assign unusedPcBits = ^{pc_decode[ADDR_W-1:IDX_W+2], pc_decode[1:0]};

  always_comb begin
    isCond     = (branch_op == 2'd1) || (branch_op == 2'd2);
    resolveNow = pendValid && !hold;
    actual     = (pendOp == 2'd1) ? (data_reg1 == data_reg2) : (data_reg1 != data_reg2);
    mispredict = resolveNow && (actual != pendPred);
    // A branch arriving while the older one mispredicts is on the wrong path.
    lookupNow  = isCond && !hold && !mispredict;

    case (MODE)
      0:       predNow = 1'b0;
      1:       predNow = 1'b1;
      default: predNow = (ctrTable[lookupIdx] >= CTR_THR);
    endcase

    curCtr = ctrTable[pendIdx];
    if (actual)
      ctrNext = (curCtr == CTR_MAX) ? curCtr : curCtr + CTR_W'(1);
    else
      ctrNext = (curCtr == '0) ? curCtr : curCtr - CTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctrTable[i] <= CTR_W'(INIT_CTR);
      pendValid        <= 1'b0;
      pendOp           <= 2'd0;
      pendIdx          <= '0;
      pendPred         <= 1'b0;
      branch_addr_mux  <= 1'b0;
      adder_mux        <= 1'b0;
      branch_redirect  <= 1'b0;
      flush            <= 1'b0;
      stat_branches    <= 16'd0;
      stat_mispredicts <= 16'd0;
    end else begin
      flush           <= 1'b0;
      adder_mux       <= 1'b0;
      branch_redirect <= 1'b0;
      if (!hold) begin
        branch_addr_mux <= lookupNow ? predNow : 1'b0;
        // A lookup in the resolve cycle reloads pending; otherwise it drains.
        if (lookupNow) begin
          pendValid <= 1'b1;
          pendOp    <= branch_op;
          pendIdx   <= lookupIdx;
          pendPred  <= predNow;
        end else begin
          pendValid <= 1'b0;
        end
        if (resolveNow) begin
          if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
          if (mispredict) begin
            if (stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
            flush           <= 1'b1;
            adder_mux       <= pendPred;
            branch_redirect <= !pendPred;
          end
          if (MODE == 2) ctrTable[pendIdx] <= ctrNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  branchOp = 2'd0;
  logic [31:0] pcDecode = 32'd0;
  logic [31:0] dataReg1 = 32'd0;
  logic [31:0] dataReg2 = 32'd0;

  logic bam, adder, redir, fl;
  logic [15:0] statBr, statMiss;
  logic bam0, adder0, redir0, fl0;
  logic [15:0] statBr0, statMiss0;
  logic bam1, adder1, redir1, fl1;
  logic [15:0] statBr1, statMiss1;

  int asserts = 0;
  int failures = 0;

  typedef struct { logic f0; logic r0; logic f1; logic a1; } static_exp_t;
  logic [3:0]  expQ [$];
  static_exp_t staticQ [$];

  always #5 clk = ~clk;

  branch_predict_unit #(.MODE(2)) dut (
    .clk(clk), .rst(rst), .hold(hold), .branch_op(branchOp), .pc_decode(pcDecode),
    .data_reg1(dataReg1), .data_reg2(dataReg2), .branch_addr_mux(bam), .adder_mux(adder),
    .branch_redirect(redir), .flush(fl), .stat_branches(statBr), .stat_mispredicts(statMiss));

  branch_predict_unit #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .branch_op(branchOp), .pc_decode(pcDecode),
    .data_reg1(dataReg1), .data_reg2(dataReg2), .branch_addr_mux(bam0), .adder_mux(adder0),
    .branch_redirect(redir0), .flush(fl0), .stat_branches(statBr0), .stat_mispredicts(statMiss0));

  branch_predict_unit #(.MODE(1)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .branch_op(branchOp), .pc_decode(pcDecode),
    .data_reg1(dataReg1), .data_reg2(dataReg2), .branch_addr_mux(bam1), .adder_mux(adder1),
    .branch_redirect(redir1), .flush(fl1), .stat_branches(statBr1), .stat_mispredicts(statMiss1));

  // One cycle of stimulus; the expected {bam,flush,adder,redirect} after the edge
  // is queued with the stimulus and popped when the registered outputs appear.
  task automatic drive(input logic r, input logic h, input logic [1:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] e, input string tag);
    logic [3:0] want;
    logic [3:0] got;
    rst = r; hold = h; branchOp = op; pcDecode = pc; dataReg1 = a; dataReg2 = b;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    got  = {bam, fl, adder, redir};
    asserts++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s {bam,flush,adder,redir} got %b expected %b", tag, got, want);
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 4'b0000, "reset_outputs");
    asserts++; if (statBr !== 16'd0 || statMiss !== 16'd0) begin failures++; $display("FAIL reset_stats got %0d/%0d expected 0/0", statBr, statMiss); end
    for (int i = 0; i < 64; i++) begin
      asserts++; if (dut.ctrTable[i] !== 2'd1) begin failures++; $display("FAIL reset_ctr[%0d] got %0d expected 1", i, dut.ctrTable[i]); end
    end
  endtask

  task automatic test_basic();
    drive(0, 0, 1, 32'h40, 0, 0, 4'b0000, "basic_lookup1");
    drive(0, 0, 0, 0, 5, 5, 4'b0101, "basic_resolve1");
    asserts++; if (dut.ctrTable[16] !== 2'd2) begin failures++; $display("FAIL basic_ctr1 got %0d expected 2", dut.ctrTable[16]); end
    asserts++; if (statBr !== 16'd1 || statMiss !== 16'd1) begin failures++; $display("FAIL basic_stats1 got %0d/%0d expected 1/1", statBr, statMiss); end
    drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "basic_lookup2");
    drive(0, 0, 0, 0, 5, 5, 4'b0000, "basic_resolve2");
    asserts++; if (dut.ctrTable[16] !== 2'd3) begin failures++; $display("FAIL basic_ctr2 got %0d expected 3", dut.ctrTable[16]); end
    asserts++; if (statBr !== 16'd2 || statMiss !== 16'd1) begin failures++; $display("FAIL basic_stats2 got %0d/%0d expected 2/1", statBr, statMiss); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "sat_lookup");
      drive(0, 0, 0, 0, 9, 9, 4'b0000, "sat_resolve");
    end
    asserts++; if (dut.ctrTable[16] !== 2'd3) begin failures++; $display("FAIL sat_ctr_max got %0d expected 3", dut.ctrTable[16]); end
    asserts++; if (statBr !== 16'd7 || statMiss !== 16'd1) begin failures++; $display("FAIL sat_stats got %0d/%0d expected 7/1", statBr, statMiss); end
    drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "sat_nt_lookup");
    drive(0, 0, 0, 0, 5, 6, 4'b0110, "sat_nt_resolve");
    asserts++; if (dut.ctrTable[16] !== 2'd2) begin failures++; $display("FAIL sat_ctr_dec got %0d expected 2", dut.ctrTable[16]); end
    drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "sat_still_taken");
    drive(0, 0, 0, 0, 5, 5, 4'b0000, "sat_still_resolve");
    asserts++; if (statBr !== 16'd9 || statMiss !== 16'd2) begin failures++; $display("FAIL sat_stats2 got %0d/%0d expected 9/2", statBr, statMiss); end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 0, 4'b0000, "b2b_reset");
    drive(0, 0, 2, 32'h10, 0, 0, 4'b0000, "b2b_bne_lookup");
    drive(0, 0, 1, 32'h14, 1, 2, 4'b0101, "b2b_squash");
    drive(0, 0, 0, 0, 1, 2, 4'b0000, "b2b_single_flush");
    asserts++; if (statBr !== 16'd1 || statMiss !== 16'd1) begin failures++; $display("FAIL b2b_stats got %0d/%0d expected 1/1", statBr, statMiss); end
    asserts++; if (dut.ctrTable[5] !== 2'd1) begin failures++; $display("FAIL b2b_squashed_ctr got %0d expected 1", dut.ctrTable[5]); end
    // Correct first prediction: pending is reloaded by the bne in the resolve cycle.
    drive(0, 0, 1, 32'h20, 0, 0, 4'b0000, "b2b_beq_lookup");
    drive(0, 0, 2, 32'h10, 1, 2, 4'b1000, "b2b_reload");
    drive(0, 0, 0, 0, 3, 4, 4'b0000, "b2b_second_resolve");
    asserts++; if (statBr !== 16'd3 || statMiss !== 16'd1) begin failures++; $display("FAIL b2b_stats2 got %0d/%0d expected 3/1", statBr, statMiss); end
    asserts++; if (dut.ctrTable[4] !== 2'd3 || dut.ctrTable[8] !== 2'd0) begin failures++; $display("FAIL b2b_ctrs got %0d/%0d expected 3/0", dut.ctrTable[4], dut.ctrTable[8]); end
  endtask

  task automatic test_hold();
    drive(1, 0, 0, 0, 0, 0, 4'b0000, "hold_reset");
    drive(0, 0, 1, 32'h40, 0, 0, 4'b0000, "hold_lookup");
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'h44, 7, 7, 4'b0000, "hold_no_flush");
    asserts++; if (statBr !== 16'd0) begin failures++; $display("FAIL hold_stats_frozen got %0d expected 0", statBr); end
    drive(0, 0, 0, 0, 7, 7, 4'b0101, "hold_deferred_flush");
    drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "hold_lookup_taken");
    drive(0, 1, 0, 0, 7, 7, 4'b1000, "hold_bam_frozen");
    drive(0, 0, 0, 0, 7, 7, 4'b0000, "hold_resolve_ok");
    asserts++; if (statBr !== 16'd2 || statMiss !== 16'd1) begin failures++; $display("FAIL hold_stats got %0d/%0d expected 2/1", statBr, statMiss); end
  endtask

  task automatic test_static_modes();
    logic [1:0]  ops [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [31:0] bs  [4] = '{32'd3, 32'd4, 32'd3, 32'd4};
    logic        act;
    static_exp_t s;
    drive(1, 0, 0, 0, 0, 0, 4'b0000, "static_reset");
    for (int i = 0; i < 4; i++) begin
      act = (ops[i] == 2'd1) ? (bs[i] == 32'd3) : (bs[i] != 32'd3);
      staticQ.push_back('{act, act, !act, !act});
      drive(0, 0, ops[i], 32'h80 + 32'(4 * i), 0, 0, 4'b0000, "static_dyn_lookup");
      asserts++; if (bam0 !== 1'b0 || bam1 !== 1'b1) begin failures++; $display("FAIL static_pred got %b/%b expected 0/1", bam0, bam1); end
      drive(0, 0, 0, 0, 3, bs[i], act ? 4'b0101 : 4'b0000, "static_dyn_resolve");
      s = staticQ.pop_front();
      asserts++; if (fl0 !== s.f0 || redir0 !== s.r0 || adder0 !== 1'b0) begin failures++; $display("FAIL static_mode0 got %b%b%b expected %b%b0", fl0, redir0, adder0, s.f0, s.r0); end
      asserts++; if (fl1 !== s.f1 || adder1 !== s.a1 || redir1 !== 1'b0) begin failures++; $display("FAIL static_mode1 got %b%b%b expected %b%b0", fl1, adder1, redir1, s.f1, s.a1); end
      asserts++; if (dut0.ctrTable[32 + i] !== 2'd1 || dut1.ctrTable[32 + i] !== 2'd1) begin failures++; $display("FAIL static_table got %0d/%0d expected 1/1", dut0.ctrTable[32 + i], dut1.ctrTable[32 + i]); end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(1, 0, 0, 0, 0, 0, 4'b0000, "rif_reset");
    drive(0, 0, 1, 32'h40, 0, 0, 4'b0000, "rif_lookup1");
    drive(0, 0, 0, 0, 5, 5, 4'b0101, "rif_resolve1");
    drive(0, 0, 1, 32'h40, 0, 0, 4'b1000, "rif_lookup2");
    drive(1, 0, 0, 0, 5, 6, 4'b0000, "rif_reset_resolve");
    drive(0, 0, 0, 0, 5, 6, 4'b0000, "rif_after");
    asserts++; if (statBr !== 16'd0 || statMiss !== 16'd0) begin failures++; $display("FAIL rif_stats got %0d/%0d expected 0/0", statBr, statMiss); end
    for (int i = 0; i < 64; i++) begin
      asserts++; if (dut.ctrTable[i] !== 2'd1) begin failures++; $display("FAIL rif_ctr[%0d] got %0d expected 1", i, dut.ctrTable[i]); end
    end
  endtask

  task automatic test_stat_saturation();
    force dut.stat_mispredicts = 16'hFFFF;
    drive(0, 0, 0, 0, 0, 0, 4'b0000, "statsat_force");
    release dut.stat_mispredicts;
    drive(0, 0, 1, 32'h40, 0, 0, 4'b0000, "statsat_lookup");
    drive(0, 0, 0, 0, 5, 5, 4'b0101, "statsat_resolve");
    asserts++; if (statMiss !== 16'hFFFF) begin failures++; $display("FAIL statsat_miss got %h expected ffff", statMiss); end
    asserts++; if (statBr !== 16'd1) begin failures++; $display("FAIL statsat_branches got %0d expected 1", statBr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_hold();
    test_static_modes();
    test_reset_in_flight();
    test_stat_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
